mem_stage_rsp: RTL and testbench
================================

// Module: mem_stage_rsp
// PURPOSE
//  Memory-access pipeline stage for a data bus with a split response (data_ok) channel.
//  Sits between EXE and WB; holds a load/store until its response returns and buffers
//  rdata if WB stalls. Extracts and extends load bytes/halfwords; feeds forwarding to decode.
//  On flush, discards responses still owed to cancelled requests.
// PARAMETERS
//  EXTRA_WD  80  width of opaque pass-through field (csr/ertn info), copied EXE->WB untouched
//  DROP_W    2   width of cancelled-response drop counter (max 2**DROP_W-1 pending drops)
// PORTS
//  clk                 in   1            clock
//  reset               in   1            synchronous, active-high reset
//  exe_to_mem_valid    in   1            EXE holds a valid instruction
//  exe_to_mem_bus      in   EXTRA_WD+75  {extra,mem_req,ld_op[2:0],ex,gr_we,dest[4:0],alu_result[31:0],pc[31:0]}
//  mem_allowin         out  1            MEM can accept from EXE this cycle
//  exe_req_outstanding in   1            EXE has a request accepted but not yet passed to MEM
//  data_sram_data_ok   in   1            response strobe for oldest outstanding request
//  data_sram_rdata     in   32           response data, valid with data_ok
//  wb_allowin          in   1            WB can accept
//  mem_to_wb_valid     out  1            result valid to WB
//  mem_to_wb_bus       out  EXTRA_WD+71  {extra,ex,gr_we,dest[4:0],final_result[31:0],pc[31:0]}
//  wb_ex               in   1            WB exception/ertn flush
//  mem_ex              out  1            mem_valid & ex
//  gr_we_mem           out  1            mem_valid & gr_we, else 0
//  dest_mem            out  5            mem_valid ? dest : 0
//  mem_fwd_ok          out  1            forward_data_mem is final (0 while load waits)
//  forward_data_mem    out  32           mem_valid ? final_result : 0
// BEHAVIOUR
//  - State: mem_valid, bus_reg, rsp_buf_valid, rsp_buf[31:0], drop_cnt[DROP_W-1:0].
//  - Reset: mem_valid=0, rsp_buf_valid=0, drop_cnt=0; all outputs 0 except mem_allowin=1.
//  - Usable response: data_ok_eff = data_sram_data_ok & (drop_cnt==0).
//  - mem_ready_go = !mem_req | ex | rsp_buf_valid | data_ok_eff.
//  - mem_allowin = !mem_valid | (mem_ready_go & wb_allowin); mem_to_wb_valid = mem_valid & mem_ready_go.
//  - Load: on data_ok_eff with mem_valid & mem_req & !rsp_buf_valid, capture into rsp_buf
//    if !wb_allowin (set rsp_buf_valid); rdata used from bus directly when passing same cycle.
//  - rsp_buf_valid clears when instruction leaves MEM (mem_to_wb_valid & wb_allowin) or on flush.
//  - Result data rd = rsp_buf_valid ? rsp_buf : data_sram_rdata; a = alu_result[1:0].
//  - ld_op: 000 none (alu_result); 001 ld.b sext rd byte a; 010 ld.bu zext byte a;
//    011 ld.h sext half a[1]; 100 ld.hu zext half a[1]; 101 ld.w rd; 110/111 -> alu_result.
//  - Stores: mem_req=1, ld_op=000; wait for data_ok, data ignored, final_result=alu_result.
//  - mem_fwd_ok = mem_valid & (ld_op==000 | rsp_buf_valid | data_ok_eff).
//  - ex=1: stage passes immediately; no response awaited (EXE does not issue req for it).
//  - Flush (wb_ex): mem_valid<=0, rsp_buf_valid<=0; drop_cnt += (mem_valid & mem_req &
//    !rsp_buf_valid & !data_ok_eff) + exe_req_outstanding, minus 1 if data_ok discarded
//    same cycle; saturates at max (assertion-flagged overflow).
//  - drop_cnt>0: each data_ok decrements by 1, response ignored; new requests still accepted.
//  - bus_reg loads on exe_to_mem_valid & mem_allowin; wb_ex has priority over accept.
//  - Single outstanding request per MEM occupancy; latency 1 cycle min when data_ok
//    arrives the cycle after entry, unbounded otherwise.
// TESTING
//  - ld.w @0x1000, data_ok 3 cycles after entry, rdata=0xDEADBEEF -> mem_to_wb_valid on
//    that cycle, final_result=0xDEADBEEF, mem_fwd_ok=0 for 2 cycles before.
//  - ld.b a=3, rdata=0x80FF_0000; ld.bu a=3 -> 0xFFFFFF80; 0x00000080; ld.h a=2 rdata
//    0x8001_0000 -> 0xFFFF8001.
//  - data_ok with wb_allowin=0 for 4 cycles -> rsp_buf holds value, result unchanged on release.
//  - wb_ex while load waits and exe_req_outstanding=1 -> drop_cnt=2; next two data_ok
//    ignored; third data_ok completes a newly entered load correctly.
//  - store with ex=0 -> held until data_ok; ex=1 instruction -> passes in 1 cycle, mem_ex=1.
//  - reset asserted mid-wait -> next cycle mem_valid=0, drop_cnt=0, mem_allowin=1.

Source files
------------

// File: rtl/mem_stage_rsp.sv
// MEM pipeline stage for a split-response data bus: holds loads/stores until data_ok,
// buffers rdata while WB stalls, extends load data and discards responses owed to flushed requests.
module mem_stage_rsp #(
  parameter int EXTRA_WD = 80,
  parameter int DROP_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exe_to_mem_valid,
  input  logic [EXTRA_WD+74:0]  exe_to_mem_bus,
  output logic                  mem_allowin,
  input  logic                  exe_req_outstanding,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  wb_allowin,
  output logic                  mem_to_wb_valid,
  output logic [EXTRA_WD+70:0]  mem_to_wb_bus,
  input  logic                  wb_ex,
  output logic                  mem_ex,
  output logic                  gr_we_mem,
  output logic [4:0]            dest_mem,
  output logic                  mem_fwd_ok,
  output logic [31:0]           forward_data_mem
);

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_BU   = 3'b010;
  localparam logic [2:0] LD_H    = 3'b011;
  localparam logic [2:0] LD_HU   = 3'b100;
  localparam logic [2:0] LD_W    = 3'b101;

  typedef struct packed {
    logic [EXTRA_WD-1:0] extra;
    logic                mem_req;
    logic [2:0]          ld_op;
    logic                ex;
    logic                gr_we;
    logic [4:0]          dest;
    logic [31:0]         alu_result;
    logic [31:0]         pc;
  } exe_bus_t;

  typedef struct packed {
    logic [EXTRA_WD-1:0] extra;
    logic                ex;
    logic                gr_we;
    logic [4:0]          dest;
    logic [31:0]         result;
    logic [31:0]         pc;
  } wb_bus_t;

  // One spare bit holds drop_cnt plus two new drops before saturation.
  typedef logic [DROP_W:0] drop_sum_t;
  localparam drop_sum_t DROP_MAX = drop_sum_t'((1 << DROP_W) - 1);

  logic                mem_valid;
  exe_bus_t            bus_reg;
  logic                rsp_buf_valid;
  logic [31:0]         rsp_buf;
  logic [DROP_W-1:0]   drop_cnt;

  logic                drop_active;
  logic                data_ok_eff;
  logic                rsp_discard;
  logic                mem_ready_go;
  logic                mem_leave;
  logic                rsp_capture;
  logic                owed_mem;
  drop_sum_t           drop_sum;
  logic                drop_ovf;
  logic [DROP_W-1:0]   drop_next;
  logic [31:0]         rd;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         final_result;
  wb_bus_t             wb_out;

  // Responses are consumed by the drop counter first; only then do they belong to MEM.
  assign drop_active  = |drop_cnt;
  assign data_ok_eff  = data_sram_data_ok & ~drop_active;
  assign rsp_discard  = data_sram_data_ok & drop_active;

  assign mem_ready_go    = ~bus_reg.mem_req | bus_reg.ex | rsp_buf_valid | data_ok_eff;
  assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go;
  assign mem_leave       = mem_to_wb_valid & wb_allowin;

  assign rsp_capture = mem_valid & bus_reg.mem_req & ~rsp_buf_valid & data_ok_eff & ~wb_allowin;
  assign owed_mem    = mem_valid & bus_reg.mem_req & ~rsp_buf_valid & ~data_ok_eff;

  assign drop_sum = drop_sum_t'(drop_cnt) + drop_sum_t'(owed_mem)
                  + drop_sum_t'(exe_req_outstanding) - drop_sum_t'(rsp_discard);
  assign drop_ovf = wb_ex & (drop_sum > DROP_MAX);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    drop_next = drop_cnt;
    if (wb_ex) begin
      drop_next = drop_ovf ? DROP_MAX[DROP_W-1:0] : drop_sum[DROP_W-1:0];
    end else if (rsp_discard) begin
      drop_next = drop_cnt - 1'b1;
    end
  end

  // Load extraction: buffered data wins over the live bus once captured.
  always_comb begin
    rd           = rsp_buf_valid ? rsp_buf : data_sram_rdata;
    ld_byte      = rd[{bus_reg.alu_result[1:0], 3'b000} +: 8];
    ld_half      = bus_reg.alu_result[1] ? rd[31:16] : rd[15:0];
    final_result = bus_reg.alu_result;
    case (bus_reg.ld_op)
      LD_B:    final_result = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   final_result = {24'h0, ld_byte};
      LD_H:    final_result = {{16{ld_half[15]}}, ld_half};
      LD_HU:   final_result = {16'h0, ld_half};
      LD_W:    final_result = rd;
      default: final_result = bus_reg.alu_result;
    endcase
  end

  always_comb begin
    wb_out = '0;
    if (mem_valid) begin
      wb_out.extra  = bus_reg.extra;
      wb_out.ex     = bus_reg.ex;
      wb_out.gr_we  = bus_reg.gr_we;
      wb_out.dest   = bus_reg.dest;
      wb_out.result = final_result;
      wb_out.pc     = bus_reg.pc;
    end
  end

  assign mem_to_wb_bus    = wb_out;
  assign mem_ex           = mem_valid & bus_reg.ex;
  assign gr_we_mem        = mem_valid & bus_reg.gr_we;
  assign dest_mem         = mem_valid ? bus_reg.dest : 5'd0;
  assign forward_data_mem = mem_valid ? final_result : 32'd0;
  assign mem_fwd_ok       = mem_valid & ((bus_reg.ld_op == LD_NONE) | rsp_buf_valid | data_ok_eff);

  // Control state: flush beats both accept and response capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      mem_valid     <= 1'b0;
      rsp_buf_valid <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      drop_cnt <= drop_next;
      if (wb_ex) begin
        mem_valid     <= 1'b0;
        rsp_buf_valid <= 1'b0;
      end else begin
        if (mem_allowin) begin
          mem_valid <= exe_to_mem_valid;
        end
        if (mem_leave) begin
          rsp_buf_valid <= 1'b0;
        end else if (rsp_capture) begin
          rsp_buf_valid <= 1'b1;
        end
      end
    end
  end

  // NOTE: payload registers carry no reset; their contents are qualified by mem_valid/rsp_buf_valid.
  always_ff @(posedge clk) begin
    if (exe_to_mem_valid & mem_allowin & ~wb_ex) begin
      bus_reg <= exe_to_mem_bus;
    end
    if (rsp_capture) begin
      rsp_buf <= data_sram_rdata;
    end
  end

`ifndef SYNTHESIS
  drop_cnt_no_overflow: assert property (@(posedge clk) disable iff (reset) !drop_ovf);
`endif

endmodule

// File: tb/tb_mem_stage_rsp.sv
// Self-checking bench for mem_stage_rsp: directed scenarios plus randomized loads/stores and
// flushes, checked against a transaction-level model of load extraction and owed responses.
module tb_mem_stage_rsp;

  localparam int EXW = 80;

  logic               clk = 1'b0;
  logic               reset;
  logic               exe_to_mem_valid;
  logic [EXW+74:0]    exe_to_mem_bus;
  logic               mem_allowin;
  logic               exe_req_outstanding;
  logic               data_sram_data_ok;
  logic [31:0]        data_sram_rdata;
  logic               wb_allowin;
  logic               mem_to_wb_valid;
  logic [EXW+70:0]    mem_to_wb_bus;
  logic               wb_ex;
  logic               mem_ex;
  logic               gr_we_mem;
  logic [4:0]         dest_mem;
  logic               mem_fwd_ok;
  logic [31:0]        forward_data_mem;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_rsp #(.EXTRA_WD(EXW), .DROP_W(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .exe_to_mem_valid    (exe_to_mem_valid),
    .exe_to_mem_bus      (exe_to_mem_bus),
    .mem_allowin         (mem_allowin),
    .exe_req_outstanding (exe_req_outstanding),
    .data_sram_data_ok   (data_sram_data_ok),
    .data_sram_rdata     (data_sram_rdata),
    .wb_allowin          (wb_allowin),
    .mem_to_wb_valid     (mem_to_wb_valid),
    .mem_to_wb_bus       (mem_to_wb_bus),
    .wb_ex               (wb_ex),
    .mem_ex              (mem_ex),
    .gr_we_mem           (gr_we_mem),
    .dest_mem            (dest_mem),
    .mem_fwd_ok          (mem_fwd_ok),
    .forward_data_mem    (forward_data_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [EXW+74:0] mk_bus(input logic [EXW-1:0] extra, input logic mreq,
                                            input logic [2:0] op, input logic exb, input logic gwe,
                                            input logic [4:0] dest, input logic [31:0] alu,
                                            input logic [31:0] pc);
    return {extra, mreq, op, exb, gwe, dest, alu, pc};
  endfunction

  // Reference load extraction from the ISA rules: shift the addressed lane down, then extend.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] alu,
                                             input logic [31:0] rdv);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdv >> (8 * alu[1:0])) & 32'hFF;
    h = (rdv >> (16 * alu[1])) & 32'hFFFF;
    case (op)
      3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      3'd5:    return rdv;
      default: return alu;
    endcase
  endfunction

  function automatic logic [EXW-1:0] rand_extra();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[EXW-1:0];
  endfunction

  task automatic idle_inputs();
    exe_to_mem_valid    = 1'b0;
    exe_to_mem_bus      = '0;
    exe_req_outstanding = 1'b0;
    data_sram_data_ok   = 1'b0;
    data_sram_rdata     = 32'h0;
    wb_allowin          = 1'b1;
    wb_ex               = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    #1;
    n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL reset_hold allowin: got %b want 1", mem_allowin); end
    n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hold valid: got %b want 0", mem_to_wb_valid); end
    reset = 1'b0;
    step();
    #1;
    n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL reset allowin: got %b want 1", mem_allowin); end
    n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_errors++; $display("FAIL reset valid: got %b want 0", mem_to_wb_valid); end
    n_checks++; if (mem_to_wb_bus !== '0) begin n_errors++; $display("FAIL reset bus: got %h want 0", mem_to_wb_bus); end
    n_checks++; if ({mem_ex, gr_we_mem, dest_mem, mem_fwd_ok} !== 8'h0) begin n_errors++; $display("FAIL reset side: got %b%b%h%b want 0", mem_ex, gr_we_mem, dest_mem, mem_fwd_ok); end
    n_checks++; if (forward_data_mem !== 32'h0) begin n_errors++; $display("FAIL reset fwd_data: got %h want 0", forward_data_mem); end
  endtask

  // One instruction through an empty stage: lat cycles without data_ok, response, stall cycles.
  task automatic run_op(input string name, input logic mreq, input logic [2:0] op, input logic exb,
                        input logic [31:0] alu, input logic [31:0] rdv, input int lat, input int stall);
    logic [EXW-1:0]  extra;
    logic [31:0]     pc;
    logic [4:0]      dest;
    logic            gwe;
    logic            needs;
    logic [31:0]     exp_res;
    logic [EXW+70:0] exp_bus;
    extra   = rand_extra();
    pc      = $urandom();
    dest    = 5'($urandom());
    gwe     = 1'($urandom());
    needs   = mreq & ~exb;
    exp_res = ref_result(op, alu, rdv);
    exp_bus = {extra, exb, gwe, dest, exp_res, pc};

    exe_to_mem_valid  = 1'b1;
    exe_to_mem_bus    = mk_bus(extra, mreq, op, exb, gwe, dest, alu, pc);
    data_sram_data_ok = 1'b0;
    wb_allowin        = 1'b1;
    #1;
    n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL %s entry_allowin: got %b want 1", name, mem_allowin); end
    step();
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus   = ~exe_to_mem_bus;

    if (needs) begin
      for (int i = 0; i < lat; i++) begin
        data_sram_rdata = $urandom();
        #1;
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_errors++; $display("FAIL %s wait_valid[%0d]: got %b want 0", name, i, mem_to_wb_valid); end
        n_checks++; if (mem_fwd_ok !== (op == 3'd0)) begin n_errors++; $display("FAIL %s wait_fwd_ok[%0d]: got %b want %b", name, i, mem_fwd_ok, op == 3'd0); end
        n_checks++; if (mem_allowin !== 1'b0) begin n_errors++; $display("FAIL %s wait_allowin[%0d]: got %b want 0", name, i, mem_allowin); end
        n_checks++; if ({gr_we_mem, dest_mem} !== {gwe, dest}) begin n_errors++; $display("FAIL %s wait_dest[%0d]: got %b/%0d want %b/%0d", name, i, gr_we_mem, dest_mem, gwe, dest); end
        step();
      end
    end

    data_sram_data_ok = needs;
    data_sram_rdata   = rdv;
    wb_allowin        = (stall == 0);
    #1;
    n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_errors++; $display("FAIL %s rsp_valid: got %b want 1", name, mem_to_wb_valid); end
    n_checks++; if (mem_fwd_ok !== 1'b1) begin n_errors++; $display("FAIL %s rsp_fwd_ok: got %b want 1", name, mem_fwd_ok); end
    n_checks++; if (forward_data_mem !== exp_res) begin n_errors++; $display("FAIL %s rsp_fwd_data: got %h want %h", name, forward_data_mem, exp_res); end
    n_checks++; if (mem_to_wb_bus !== exp_bus) begin n_errors++; $display("FAIL %s rsp_bus: got %h want %h", name, mem_to_wb_bus, exp_bus); end
    n_checks++; if (mem_ex !== exb) begin n_errors++; $display("FAIL %s mem_ex: got %b want %b", name, mem_ex, exb); end
    n_checks++; if (mem_allowin !== (stall == 0)) begin n_errors++; $display("FAIL %s rsp_allowin: got %b want %b", name, mem_allowin, stall == 0); end
    step();
    data_sram_data_ok = 1'b0;

    for (int s = 0; s < stall; s++) begin
      data_sram_rdata = ~rdv;
      wb_allowin      = (s == stall - 1);
      #1;
      n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_errors++; $display("FAIL %s stall_valid[%0d]: got %b want 1", name, s, mem_to_wb_valid); end
      n_checks++; if (mem_to_wb_bus !== exp_bus) begin n_errors++; $display("FAIL %s stall_bus[%0d]: got %h want %h", name, s, mem_to_wb_bus, exp_bus); end
      n_checks++; if (mem_fwd_ok !== 1'b1) begin n_errors++; $display("FAIL %s stall_fwd_ok[%0d]: got %b want 1", name, s, mem_fwd_ok); end
      n_checks++; if (mem_allowin !== (s == stall - 1)) begin n_errors++; $display("FAIL %s stall_allowin[%0d]: got %b want %b", name, s, mem_allowin, s == stall - 1); end
      step();
    end

    wb_allowin = 1'b1;
    #1;
    n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_errors++; $display("FAIL %s drained_valid: got %b want 0", name, mem_to_wb_valid); end
    n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL %s drained_allowin: got %b want 1", name, mem_allowin); end
  endtask

  task automatic test_directed();
    run_op("ldw_lat3",   1'b1, 3'd5, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 2, 0);
    run_op("ldb_a3",     1'b1, 3'd1, 1'b0, 32'h0000_1003, 32'h80FF_0000, 1, 0);
    run_op("ldbu_a3",    1'b1, 3'd2, 1'b0, 32'h0000_1003, 32'h80FF_0000, 0, 0);
    run_op("ldh_a2",     1'b1, 3'd3, 1'b0, 32'h0000_1002, 32'h8001_0000, 1, 0);
    run_op("ldw_stall4", 1'b1, 3'd5, 1'b0, 32'h0000_2000, 32'h1234_5678, 0, 4);
    run_op("store_wait", 1'b1, 3'd0, 1'b0, 32'h0000_3004, 32'hA5A5_5A5A, 3, 0);
    run_op("ex_pass",    1'b1, 3'd0, 1'b1, 32'h0000_4008, 32'h0000_0000, 0, 0);
  endtask

  task automatic test_random_ops();
    logic       exb;
    logic       mreq;
    logic [2:0] op;
    for (int it = 0; it < 30; it++) begin
      exb  = ($urandom_range(0, 7) == 0);
      mreq = 1'($urandom());
      op   = (mreq && !exb) ? 3'($urandom_range(0, 7)) : 3'd0;
      run_op("rand_op", mreq, op, exb, $urandom(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  // Streams instructions with an overlapping enter/leave every cycle, including a 1-cycle load.
  task automatic test_back_to_back();
    logic [EXW+74:0] in_bus [5];
    logic [EXW+70:0] exp_bus [5];
    logic [31:0]     rdv;
    logic [EXW-1:0]  extra;
    logic [31:0]     alu;
    logic [31:0]     pc;
    logic [4:0]      dest;
    logic            mreq;
    logic [2:0]      op;
    rdv = $urandom();
    for (int k = 0; k < 5; k++) begin
      extra = rand_extra();
      alu   = $urandom();
      pc    = $urandom();
      dest  = 5'($urandom());
      mreq  = (k == 3);
      op    = (k == 3) ? 3'd4 : 3'd0;
      in_bus[k]  = mk_bus(extra, mreq, op, 1'b0, 1'b1, dest, alu, pc);
      exp_bus[k] = {extra, 1'b0, 1'b1, dest, ref_result(op, alu, rdv), pc};
    end
    wb_allowin = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exe_to_mem_valid  = (c < 5);
      exe_to_mem_bus    = (c < 5) ? in_bus[c] : '0;
      data_sram_data_ok = (c == 4);
      data_sram_rdata   = (c == 4) ? rdv : $urandom();
      #1;
      n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL b2b allowin[%0d]: got %b want 1", c, mem_allowin); end
      if (c > 0) begin
        n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_errors++; $display("FAIL b2b valid[%0d]: got %b want 1", c, mem_to_wb_valid); end
        n_checks++; if (mem_to_wb_bus !== exp_bus[c-1]) begin n_errors++; $display("FAIL b2b bus[%0d]: got %h want %h", c, mem_to_wb_bus, exp_bus[c-1]); end
      end
      step();
    end
    idle_inputs();
    #1;
    n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_errors++; $display("FAIL b2b drained_valid: got %b want 0", mem_to_wb_valid); end
  endtask

  // Flush with a waiting load and one request still in EXE: two responses are owed.
  task automatic test_flush_drop();
    logic [31:0] rdv;
    logic [31:0] exp_res;
    idle_inputs();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(rand_extra(), 1'b1, 3'd5, 1'b0, 1'b1, 5'd7, 32'h0000_1000, $urandom());
    step();
    exe_to_mem_valid = 1'b0;
    step();
    wb_ex               = 1'b1;
    exe_req_outstanding = 1'b1;
    exe_to_mem_valid    = 1'b1;
    exe_to_mem_bus      = mk_bus(rand_extra(), 1'b1, 3'd5, 1'b0, 1'b1, 5'd8, 32'h0000_1004, $urandom());
    step();
    wb_ex               = 1'b0;
    exe_req_outstanding = 1'b0;
    exe_to_mem_valid    = 1'b0;
    #1;
    n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_errors++; $display("FAIL flush valid: got %b want 0", mem_to_wb_valid); end
    n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL flush allowin: got %b want 1", mem_allowin); end
    rdv     = 32'hC0DE_F00D;
    exp_res = ref_result(3'd1, 32'h0000_2001, rdv);
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(rand_extra(), 1'b1, 3'd1, 1'b0, 1'b1, 5'd9, 32'h0000_2001, $urandom());
    step();
    exe_to_mem_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = $urandom();
      #1;
      n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_errors++; $display("FAIL flush drop%0d_valid: got %b want 0", d, mem_to_wb_valid); end
      n_checks++; if (mem_fwd_ok !== 1'b0) begin n_errors++; $display("FAIL flush drop%0d_fwd_ok: got %b want 0", d, mem_fwd_ok); end
      step();
    end
    data_sram_rdata = rdv;
    #1;
    n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_errors++; $display("FAIL flush third_valid: got %b want 1", mem_to_wb_valid); end
    n_checks++; if (forward_data_mem !== exp_res) begin n_errors++; $display("FAIL flush third_data: got %h want %h", forward_data_mem, exp_res); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL flush drained_allowin: got %b want 1", mem_allowin); end
  endtask

  // Random flush timing; the model only counts owed responses and ignores that many data_ok.
  task automatic test_flush_random();
    int          owed;
    logic        eo;
    logic        dok;
    logic        done;
    logic [31:0] rdv;
    logic [31:0] alu;
    logic [2:0]  op;
    logic [EXW+74:0] nbus;
    for (int it = 0; it < 12; it++) begin
      idle_inputs();
      exe_to_mem_valid = 1'b1;
      exe_to_mem_bus   = mk_bus(rand_extra(), 1'b1, 3'd5, 1'b0, 1'b1, 5'd1, $urandom(), $urandom());
      step();
      exe_to_mem_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      eo                  = 1'($urandom());
      wb_ex               = 1'b1;
      exe_req_outstanding = eo;
      exe_to_mem_valid    = eo;
      exe_to_mem_bus      = mk_bus(rand_extra(), 1'b1, 3'd5, 1'b0, 1'b1, 5'd2, $urandom(), $urandom());
      owed = 1 + int'(eo);
      step();
      wb_ex               = 1'b0;
      exe_req_outstanding = 1'b0;
      exe_to_mem_valid    = 1'b0;
      #1;
      n_checks++; if ({mem_to_wb_valid, mem_allowin} !== 2'b01) begin n_errors++; $display("FAIL rflush[%0d] flushed: got %b%b want 01", it, mem_to_wb_valid, mem_allowin); end

      alu  = $urandom();
      op   = 3'($urandom_range(1, 5));
      rdv  = $urandom();
      nbus = mk_bus(rand_extra(), 1'b1, op, 1'b0, 1'b1, 5'd3, alu, $urandom());
      exe_to_mem_valid  = 1'b1;
      exe_to_mem_bus    = nbus;
      dok               = 1'($urandom());
      data_sram_data_ok = dok;
      data_sram_rdata   = $urandom();
      if (dok) owed--;
      step();
      exe_to_mem_valid  = 1'b0;
      data_sram_data_ok = 1'b0;

      if (owed > 0 && $urandom_range(0, 1) == 1) begin
        // Second flush while a discarded response lands: owed count is unchanged.
        wb_ex             = 1'b1;
        data_sram_data_ok = 1'b1;
        step();
        wb_ex             = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        n_checks++; if ({mem_to_wb_valid, mem_allowin} !== 2'b01) begin n_errors++; $display("FAIL rflush[%0d] reflushed: got %b%b want 01", it, mem_to_wb_valid, mem_allowin); end
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = nbus;
        step();
        exe_to_mem_valid = 1'b0;
      end

      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        dok               = 1'($urandom());
        data_sram_data_ok = dok;
        data_sram_rdata   = (dok && owed == 0) ? rdv : $urandom();
        #1;
        if (dok && owed == 0) begin
          n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_errors++; $display("FAIL rflush[%0d] done_valid: got %b want 1", it, mem_to_wb_valid); end
          n_checks++; if (forward_data_mem !== ref_result(op, alu, rdv)) begin n_errors++; $display("FAIL rflush[%0d] done_data: got %h want %h", it, forward_data_mem, ref_result(op, alu, rdv)); end
          done = 1'b1;
        end else begin
          n_checks++; if ({mem_to_wb_valid, mem_fwd_ok} !== 2'b00) begin n_errors++; $display("FAIL rflush[%0d] wait[%0d]: got valid/fwd_ok %b%b want 00", it, c, mem_to_wb_valid, mem_fwd_ok); end
        end
        if (dok && owed > 0) owed--;
        step();
      end
      data_sram_data_ok = 1'b0;
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rflush[%0d] timeout: got no completion want completion", it); end
      #1;
      n_checks++; if ({mem_to_wb_valid, mem_allowin} !== 2'b01) begin n_errors++; $display("FAIL rflush[%0d] drained: got %b%b want 01", it, mem_to_wb_valid, mem_allowin); end
    end
  endtask

  task automatic test_reset_midwait();
    logic [31:0] rdv;
    idle_inputs();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(rand_extra(), 1'b1, 3'd5, 1'b0, 1'b1, 5'd4, $urandom(), $urandom());
    step();
    exe_to_mem_valid    = 1'b0;
    wb_ex               = 1'b1;
    exe_req_outstanding = 1'b1;
    step();
    wb_ex               = 1'b0;
    exe_req_outstanding = 1'b0;
    exe_to_mem_valid    = 1'b1;
    exe_to_mem_bus      = mk_bus(rand_extra(), 1'b1, 3'd5, 1'b0, 1'b1, 5'd5, $urandom(), $urandom());
    step();
    exe_to_mem_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_checks++; if ({mem_to_wb_valid, mem_allowin} !== 2'b01) begin n_errors++; $display("FAIL rst_mid valid/allowin: got %b%b want 01", mem_to_wb_valid, mem_allowin); end
    n_checks++; if ({gr_we_mem, dest_mem, mem_fwd_ok} !== 7'h0) begin n_errors++; $display("FAIL rst_mid side: got %b/%0d/%b want 0", gr_we_mem, dest_mem, mem_fwd_ok); end
    n_checks++; if (mem_to_wb_bus !== '0) begin n_errors++; $display("FAIL rst_mid bus: got %h want 0", mem_to_wb_bus); end
    rdv = $urandom();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(rand_extra(), 1'b1, 3'd5, 1'b0, 1'b1, 5'd6, 32'h0000_5000, $urandom());
    step();
    exe_to_mem_valid  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdv;
    #1;
    n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_errors++; $display("FAIL rst_mid no_drop_valid: got %b want 1", mem_to_wb_valid); end
    n_checks++; if (forward_data_mem !== rdv) begin n_errors++; $display("FAIL rst_mid no_drop_data: got %h want %h", forward_data_mem, rdv); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (mem_allowin !== 1'b1) begin n_errors++; $display("FAIL rst_mid drained_allowin: got %b want 1", mem_allowin); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush_drop();
    test_random_ops();
    test_flush_random();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
